// File: rtl/timer_multi.sv
// Multi-channel programmable interval timer: NUM_CH independent one-shot/periodic
// channels counting ticks from one shared prescaler, each with a 1-cycle expiry pulse.
module timer_multi #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 21,
    parameter int PRESC_W = 8
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [PRESC_W-1:0]        PRESC_DIV,
    input  logic [NUM_CH-1:0]         START,
    input  logic [NUM_CH-1:0]         STOP,
    input  logic [NUM_CH-1:0]         PERIODIC,
    input  logic [NUM_CH*CNT_W-1:0]   LOAD_VAL,
    output logic [NUM_CH-1:0]         PULSE,
    output logic [NUM_CH-1:0]         BUSY
);

    typedef enum logic {ST_IDLE = 1'b0, ST_COUNT = 1'b1} state_t;

    logic [PRESC_W-1:0] presc_cnt;
    logic               tick;

    // A ">=" compare means lowering PRESC_DIV below presc_cnt ticks at once instead of wrapping.
    assign tick = (presc_cnt >= PRESC_DIV);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            presc_cnt <= '0;
        end else if (tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 1'b1;
        end
    end

    // Strobes are single-cycle level inputs with no handshake: each is acted on
    // at the edge where it is high, and STOP outranks START, which outranks expiry.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t           state;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] reload;
        logic             mode;
        logic             pulse_r;

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                state   <= ST_IDLE;
                cnt     <= '0;
                reload  <= '0;
                mode    <= 1'b0;
                pulse_r <= 1'b0;
            end else begin
                pulse_r <= 1'b0;
                if (STOP[i]) begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end else if (START[i]) begin
                    reload <= LOAD_VAL[i*CNT_W +: CNT_W];
                    mode   <= PERIODIC[i];
                    cnt    <= '0;
                    state  <= ST_COUNT;
                end else if (state == ST_COUNT && tick) begin
                    if (cnt == reload) begin
                        pulse_r <= 1'b1;
                        cnt     <= '0;
                        if (!mode) begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end
        end

        assign PULSE[i] = pulse_r;
        assign BUSY[i]  = (state == ST_COUNT);
    end

endmodule

// File: tb/tb_timer_multi.sv
// Bench for timer_multi: directed scenarios plus random strobes, checked every
// cycle against a down-counting reference model through an expected-value queue.
module tb_timer_multi;
    localparam int NUM_CH  = 4;
    localparam int CNT_W   = 21;
    localparam int PRESC_W = 8;
    localparam int OUT_W   = 2 * NUM_CH;

    logic                    CLK;
    logic                    RST_N;
    logic [PRESC_W-1:0]      PRESC_DIV;
    logic [NUM_CH-1:0]       START;
    logic [NUM_CH-1:0]       STOP;
    logic [NUM_CH-1:0]       PERIODIC;
    logic [NUM_CH*CNT_W-1:0] LOAD_VAL;
    logic [NUM_CH-1:0]       PULSE;
    logic [NUM_CH-1:0]       BUSY;

    timer_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W)) dut (
        .CLK(CLK), .RST_N(RST_N), .PRESC_DIV(PRESC_DIV), .START(START), .STOP(STOP),
        .PERIODIC(PERIODIC), .LOAD_VAL(LOAD_VAL), .PULSE(PULSE), .BUSY(BUSY)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;
    logic [OUT_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t actual pulse=%b busy=%b expected pulse=%b busy=%b",
                     name, $time, act[OUT_W-1:NUM_CH], act[NUM_CH-1:0],
                     exp[OUT_W-1:NUM_CH], exp[NUM_CH-1:0]);
        end
    endtask

    // Reference model: each active channel holds the number of ticks still to
    // wait; a START arms it with L+1, and it pulses when that reaches zero.
    int           m_p;
    bit           m_act [NUM_CH];
    longint       m_rem [NUM_CH];
    longint       m_load[NUM_CH];
    bit           m_per [NUM_CH];
    bit           m_tick;
    logic [NUM_CH-1:0] m_pv;
    logic [NUM_CH-1:0] m_bv;

    initial begin
        forever begin
            @(posedge CLK or negedge RST_N);
            if (!RST_N) begin
                m_p = 0;
                for (int i = 0; i < NUM_CH; i++) begin
                    m_act[i] = 0; m_rem[i] = 0; m_load[i] = 0; m_per[i] = 0;
                end
                exp_q.delete();
            end else begin
                m_tick = (m_p >= int'(PRESC_DIV));
                m_p = m_tick ? 0 : m_p + 1;
                m_pv = '0;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (STOP[i]) begin
                        m_act[i] = 0;
                    end else if (START[i]) begin
                        m_act[i]  = 1;
                        m_load[i] = longint'(LOAD_VAL[i*CNT_W +: CNT_W]);
                        m_per[i]  = PERIODIC[i];
                        m_rem[i]  = m_load[i] + 1;
                    end else if (m_act[i] && m_tick) begin
                        m_rem[i] = m_rem[i] - 1;
                        if (m_rem[i] == 0) begin
                            m_pv[i] = 1'b1;
                            if (m_per[i]) m_rem[i] = m_load[i] + 1;
                            else m_act[i] = 0;
                        end
                    end
                    m_bv[i] = m_act[i];
                end
                exp_q.push_back({m_pv, m_bv});
            end
        end
    end

    // monitor: outputs are sampled on the falling edge, one expectation per rising edge
    initial begin
        forever begin
            @(negedge CLK);
            if (RST_N && exp_q.size() > 0) begin
                check("pulse_busy", {PULSE, BUSY}, exp_q.pop_front());
            end
        end
    end

    // driver tasks: inputs change 1 time unit after the rising edge
    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic start_ch(input int ch, input int unsigned load, input bit per);
        START[ch] = 1'b1;
        PERIODIC[ch] = per;
        LOAD_VAL[ch*CNT_W +: CNT_W] = CNT_W'(load);
    endtask

    task automatic clear_strobes();
        START = '0;
        STOP  = '0;
    endtask

    initial begin
        RST_N = 1'b0; PRESC_DIV = '0; START = '0; STOP = '0; PERIODIC = '0; LOAD_VAL = '0;
        #2;
        check("reset_outputs", {PULSE, BUSY}, '0);
        step(3);
        RST_N = 1'b1;
        step(2);

        // one-shot L=4, every cycle a tick
        start_ch(0, 4, 1'b0); step(1); clear_strobes(); step(10);

        // periodic L=2, then STOP
        start_ch(1, 2, 1'b1); step(1); clear_strobes(); step(12);
        STOP[1] = 1'b1; step(1); clear_strobes(); step(6);

        // periodic L=1 with tick period 4
        PRESC_DIV = 8'd3;
        start_ch(2, 1, 1'b1); step(1); clear_strobes(); step(40);
        STOP[2] = 1'b1; step(1); clear_strobes(); step(2);

        // retrigger at edge 3 restarts the count
        PRESC_DIV = 8'd0;
        start_ch(0, 5, 1'b0); step(1); clear_strobes(); step(2);
        start_ch(0, 5, 1'b0); step(1); clear_strobes(); step(12);

        // START and STOP together; STOP on the expiry edge
        start_ch(3, 1, 1'b1); STOP[3] = 1'b1; step(1); clear_strobes(); step(5);
        start_ch(0, 2, 1'b0); step(1); clear_strobes(); step(2);
        STOP[0] = 1'b1; step(1); clear_strobes(); step(4);

        // all channels L=0 expire together; retrigger on an expiry edge
        for (int i = 0; i < NUM_CH; i++) start_ch(i, 0, 1'b1);
        step(1); clear_strobes(); step(4);
        start_ch(2, 3, 1'b0); step(1); clear_strobes(); step(6);
        STOP = '1; step(1); clear_strobes(); step(2);

        // lowering PRESC_DIV below the running prescaler count; load changes while counting
        PRESC_DIV = 8'd50;
        start_ch(1, 3, 1'b1); step(1); clear_strobes();
        LOAD_VAL[1*CNT_W +: CNT_W] = CNT_W'(0); PERIODIC[1] = 1'b0;
        step(30);
        PRESC_DIV = 8'd2; step(30);
        STOP = '1; step(1); clear_strobes(); step(2);

        // asynchronous reset in mid-count, then a quiet period
        PRESC_DIV = 8'd0;
        for (int i = 0; i < NUM_CH; i++) start_ch(i, 7, 1'b1);
        step(1); clear_strobes(); step(3);
        #2;
        RST_N = 1'b0;
        #1;
        check("async_reset", {PULSE, BUSY}, '0);
        step(2);
        check("reset_held", {PULSE, BUSY}, '0);
        RST_N = 1'b1;
        step(100);

        // random strobes, modes, loads and prescaler settings
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                START[i] = ($urandom_range(0, 15) == 0);
                STOP[i]  = ($urandom_range(0, 40) == 0);
                PERIODIC[i] = 1'($urandom_range(0, 1));
                LOAD_VAL[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 99) == 0) PRESC_DIV = PRESC_W'($urandom_range(0, 4));
            step(1);
        end
        clear_strobes();
        step(20);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge CLK);
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain actual pending=%0d required pending=0", exp_q.size());
        end
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
